// File: rtl/alu_commit.sv
`default_nettype none
// ============================================================================
// Module   : alu_commit
// Purpose  : Execute-side neighbour of the ALU. Owns the architectural
//            register file and the F1/F2 flag pair that source the ALU, and
//            consumes the ALU results (C, addrch, naddr, F3) to write back,
//            update flags and advance the program counter. A two-state
//            issue/commit sequencer (ACCEPT -> COMMIT -> ACCEPT) gives one
//            instruction every two cycles; HALT_OP parks it in HALT until
//            reset.
// Ports    : clock/reset       - system clock, async active-high reset
//            in_valid/in_ready - issue handshake
//            instr/dst/srca/srcb - opcode, destination and read indices
//            rd_a/rd_b/reg8    - register read ports feeding the ALU
//            C/addrch/naddr/F3 - ALU results captured on acceptance
//            F1/F2             - flag registers feeding the ALU
//            pc/halted         - program counter and halt status
// Option   : ALU_COMMIT_RETIRE_CNT_EN adds outputs retired[31:0] (count of
//            committed instructions) and retire_pulse (high in COMMIT).
// Revision : 1.0 - initial release
// ============================================================================
module alu_commit #(
  parameter int          NREGS    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'd63
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               instr,
  input  logic [$clog2(NREGS)-1:0] dst,
  input  logic [$clog2(NREGS)-1:0] srca,
  input  logic [$clog2(NREGS)-1:0] srcb,
  output logic [31:0]              rd_a,
  output logic [31:0]              rd_b,
  output logic [31:0]              reg8,
  input  logic [31:0]              C,
  input  logic                     addrch,
  input  logic [31:0]              naddr,
  input  logic                     F3,
  output logic                     F1,
  output logic                     F2,
  output logic [31:0]              pc,
`ifdef ALU_COMMIT_RETIRE_CNT_EN
  output logic [31:0]              retired,
  output logic                     retire_pulse,
`endif
  output logic                     halted
);

  localparam int                 AW       = $clog2(NREGS);
  localparam logic [AW-1:0]      REG8_IDX = AW'(8);

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  logic [1:0]    state_q, state_d;

  // Payload captured on the accept edge, consumed during COMMIT.
  logic [5:0]    instr_q,  instr_d;
  logic [AW-1:0] dst_q,    dst_d;
  logic [31:0]   c_q,      c_d;
  logic          addrch_q, addrch_d;
  logic [31:0]   naddr_q,  naddr_d;
  logic          f3_q,     f3_d;

  // Architectural state.
  logic [31:0]   regs_q [NREGS];
  logic [31:0]   regs_d [NREGS];
  logic          f1_q, f1_d;
  logic          f2_q, f2_d;
  logic [31:0]   pc_q, pc_d;

  logic          accept;
  logic          commit;

  // --------------------------------------------------------------------------
  // Sequencer: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCEPT: begin
        if (in_valid) begin
          state_d = (instr == HALT_OP) ? ST_HALT : ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_ACCEPT;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_ACCEPT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    halted   = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_ACCEPT: in_ready = 1'b1;
      ST_COMMIT: commit   = 1'b1;
      ST_HALT:   halted   = 1'b1;
      default:   in_ready = 1'b0;
    endcase
  end

  assign accept = in_ready & in_valid;

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    instr_d  = instr_q;
    dst_d    = dst_q;
    c_d      = c_q;
    addrch_d = addrch_q;
    naddr_d  = naddr_q;
    f3_d     = f3_q;
    regs_d   = regs_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    pc_d     = pc_q;

    // The ALU is combinational from rd_a/rd_b/F1/F2, so its outputs belong
    // to the instruction presented in the same cycle.
    if (accept) begin
      instr_d  = instr;
      dst_d    = dst;
      c_d      = C;
      addrch_d = addrch;
      naddr_d  = naddr;
      f3_d     = F3;
    end

    if (commit) begin
      // Register 0 stays zero: its write is simply dropped.
      if ((instr_q < 6'd8) && (dst_q != '0)) begin
        regs_d[dst_q] = c_q;
      end
      // Compare-class opcodes shift the flag pair.
      if ((instr_q >= 6'd8) && (instr_q <= 6'd13)) begin
        f2_d = f1_q;
        f1_d = f3_q;
      end
      pc_d = addrch_q ? naddr_q : (pc_q + 32'd1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q  <= '0;
      dst_q    <= '0;
      c_q      <= '0;
      addrch_q <= 1'b0;
      naddr_q  <= '0;
      f3_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      pc_q     <= RESET_PC;
    end else begin
      instr_q  <= instr_d;
      dst_q    <= dst_d;
      c_q      <= c_d;
      addrch_q <= addrch_d;
      naddr_q  <= naddr_d;
      f3_q     <= f3_d;
      regs_q   <= regs_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      pc_q     <= pc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: straight from the array, no bypass (reads and writes never
  // overlap because nothing is accepted during COMMIT).
  // --------------------------------------------------------------------------
  assign rd_a = (srca == '0) ? 32'd0 : regs_q[srca];
  assign rd_b = (srcb == '0) ? 32'd0 : regs_q[srcb];
  assign reg8 = regs_q[REG8_IDX];
  assign F1   = f1_q;
  assign F2   = f2_q;
  assign pc   = pc_q;

`ifdef ALU_COMMIT_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q + {31'd0, commit};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired      = retired_q;
  assign retire_pulse = commit;
`endif

endmodule
`default_nettype wire

// File: doc/alu_commit.md
Name: alu_commit

Overview:
- Execute-side neighbour of the ALU.
- Holds the architectural register file that sources the ALU operands: A, B and the reg8 branch target.
- Holds the F1/F2 condition flags that feed the ALU.
- Consumes the ALU outputs (C, addrch, naddr, F3) to commit results, update flags and advance the program counter.
- Sits between the decode/issue logic and the ALU. Uses a valid/ready handshake with a two-state issue/commit sequencer.

Parameters:
NREGS, 16, number of 32-bit architectural registers (power of two, >= 9 so register 8 exists)
RESET_PC, 32'h0000_0000, program counter value loaded on reset
HALT_OP, 6'd63, instr code that halts the sequencer

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  issue slot holds a valid instruction
in_ready  output  1  block accepts an instruction this cycle
instr  input  6  opcode, same encoding as the ALU instr input
dst  input  $clog2(NREGS)  destination register index
srca  input  $clog2(NREGS)  read port A index
srcb  input  $clog2(NREGS)  read port B index
rd_a  output  32  register[srca], drives ALU A (combinational)
rd_b  output  32  register[srcb], drives ALU B (combinational)
reg8  output  32  register[8], drives ALU reg8
C  input  32  ALU result
addrch  input  1  ALU branch-taken indication
naddr  input  32  ALU branch target
F3  input  1  ALU compare/flag result
F1  output  1  flag register 1 to ALU
F2  output  1  flag register 2 to ALU
pc  output  32  current program counter
halted  output  1  sequencer is in HALT

Behaviour:
- Reset (asynchronous, any state, including mid-commit):
  - All registers 0, F1=F2=0, pc=RESET_PC.
  - State ACCEPT, in_ready=1, halted=0.
  - A pending commit is discarded.
- Register 0 is hardwired zero: reads return 0, writes are ignored.
- Read ports are combinational from the current array contents. There is no bypass; the sequencer guarantees no read/write overlap.
- State ACCEPT:
  - in_ready=1.
  - On in_valid=1, capture instr, dst, C, addrch, naddr and F3 from the same cycle (ALU is combinational from rd_a/rd_b/F1/F2), then go to COMMIT.
  - If the captured instr==HALT_OP, go to HALT instead and commit nothing.
  - in_valid=0: remain in ACCEPT.
- State COMMIT (exactly one cycle, in_ready=0). All updates occur at the end of this cycle, simultaneously:
  - Writeback: instr 0..7 write captured C to register[dst]. Instr 8..15 and unused codes do not write.
  - Flags:
    - Instr 8..13: F2<=old F1, F1<=captured F3.
    - All other codes: flags hold.
  - PC:
    - addrch=1: pc<=naddr.
    - Otherwise pc<=pc+1, wrapping from 32'hFFFF_FFFF to 0.
  - Return to ACCEPT.
- Throughput is one instruction per two cycles. Latency from acceptance to visible register/flag/pc update is 1 cycle after the accept edge.
- State HALT:
  - in_ready=0, halted=1; registers, flags and pc frozen.
  - Only reset exits HALT.
- Unused instr codes (16..62) commit as no-ops with pc+1.
- dst outside 0..NREGS-1 cannot occur (width exact).

Optional Feature:
- Macro ALU_COMMIT_RETIRE_CNT_EN.
- Defined:
  - Adds output retired  32 bits: a count of committed instructions.
  - Increments at the end of each COMMIT cycle; halt is not counted.
  - Reset to 0; wraps to 0 after 32'hFFFF_FFFF.
  - Also adds 1-bit output retire_pulse, high during each COMMIT cycle.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Assert reset mid-COMMIT (instr 0, dst 3, C=32'h1234) -> r3 stays 0, pc=RESET_PC, in_ready=1 immediately, without waiting for a clock edge.
- Issue instr 0, dst 5, C=32'hDEAD_BEEF -> in_ready low one cycle; next cycle rd_a with srca=5 reads 32'hDEAD_BEEF; pc 0->1.
- Issue instr 0, dst 0, C=32'hFFFF_FFFF -> rd_a with srca=0 still returns 0.
- Issue instr 8 with F3=1, then instr 9 with F3=0 -> after the first, F1=1/F2=0; after the second, F1=0/F2=1; no register written.
- Issue instr 14 with addrch=1, naddr=32'h0000_0040 -> pc=32'h40; then instr 15 with addrch=0 -> pc=32'h41.
- Back-to-back in_valid held high for 4 instructions -> exactly 4 commits in 8 cycles. Then issue HALT_OP -> halted=1 and in_ready=0 forever; pc unchanged; retired=4 (feature enabled).
